dcpu16_mbus: RTL and testbench
==============================

DCPU16_MBUS -- requirements
Module: dcpu16_mbus

Interface
REQ-001 Parameter: TMO, 8, bus-timeout cycles in BUSY before abort (legal range 2..255).
REQ-002 Parameter: STV, 3, consecutive F-port losses before F is forced to win (legal range 1..15).
REQ-003 clk  in  1  single clock, all flops on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 f_adr in 16, f_stb in 1, f_dti out 16, f_ack out 1: fetch port, read-only.
REQ-006 ab_adr in 16, ab_stb in 1, ab_dti out 16, ab_ack out 1: operand-load port, read-only.
REQ-007 cc_adr in 16, cc_stb in 1, cc_wre in 1, cc_dto in 16, cc_dti out 16, cc_ack out 1: write-back port, read or write.
REQ-008 wb_adr out 16, wb_stb out 1, wb_wre out 1, wb_dto out 16, wb_dti in 16, wb_ack in 1: shared memory master, simplified Wishbone.
REQ-009 err  out  1  one-cycle pulse coincident with the requester ack of an aborted transfer.

Function
REQ-010 FSM states IDLE, BUSY, DONE; only IDLE arbitrates.
REQ-011 IDLE: no stb -> stay IDLE; any stb -> latch grant, adr, wre, dto; go BUSY.
REQ-012 Priority CC > AB > F, except when starvation count = STV and f_stb=1: F wins.
REQ-013 Starvation count: 4-bit; +1 when F requests in IDLE and loses; cleared when F granted; saturates at STV.
REQ-014 BUSY: wb_stb=1; wb_adr/wb_wre/wb_dto driven from latched values, stable for the whole transfer.
REQ-015 F and AB grants drive wb_wre=0 and wb_dto=0; CC grant drives cc_wre/cc_dto as latched.
REQ-016 BUSY & wb_ack -> DONE; wb_dti captured into the granted port's dti register.
REQ-017 BUSY timeout: cycle counter cleared on BUSY entry; when it reaches TMO without wb_ack -> DONE, dti register = 16'hFFFF, err pulsed in DONE.
REQ-018 wb_ack and timeout in the same cycle: ack wins, no err.
REQ-019 DONE: wb_stb=0; granted port's ack=1 for exactly one cycle; next state IDLE unconditionally.
REQ-020 Requester holds stb and inputs until its ack; drops or re-presents stb on the edge after ack.
REQ-021 Latency with zero-wait memory: stb seen in IDLE at N -> wb_stb at N+1..N+1 -> ack at N+2 -> re-arbitration at N+3; minimum 3 cycles per transfer.
REQ-022 Non-granted ports: ack=0; their dti registers hold last value.
REQ-023 wb_ack outside BUSY is ignored.
REQ-024 Requester dropping stb mid-transfer does not abort; the transfer completes and ack is still issued.
REQ-025 At most one of f_ack, ab_ack, cc_ack is high in any cycle.

Reset
REQ-026 rst asserted, any state -> IDLE immediately, without waiting for a clock edge.
REQ-027 Reset values: wb_stb=0, wb_wre=0, wb_adr=0, wb_dto=0, all acks=0, err=0, all dti=0, grant=none, starvation count=0, timeout counter=0.
REQ-028 Reset during BUSY: wb_stb drops immediately; pending transfer is lost with no ack; a later wb_ack is ignored.

Verification
REQ-029 Single F read, f_adr=16'h0010, wb_ack on first BUSY cycle with wb_dti=16'h7C01 -> f_ack one cycle 2 cycles after grant, f_dti=16'h7C01, err=0.
REQ-030 CC write and AB read both requested in the same IDLE cycle (cc_adr=16'h1000, cc_dto=16'hBEEF, cc_wre=1) -> CC served first with wb_wre=1, wb_dto=16'hBEEF; AB served next with wb_wre=0.
REQ-031 F requesting continuously while AB re-requests after every ack, STV=3 -> AB wins 3 times, F wins the 4th arbitration, starvation count clears.
REQ-032 AB read with wb_ack never asserted, TMO=8 -> DONE after 8 BUSY cycles, ab_ack=1, err=1, ab_dti=16'hFFFF, wb_stb=0.
REQ-033 wb_ack and timeout in the same cycle -> normal completion, dti=wb_dti, err=0.
REQ-034 rst pulsed mid-BUSY between clock edges -> wb_stb=0 before next edge, no ack; a stray wb_ack afterwards produces no ack.

Source files
------------

// File: rtl/dcpu16_mbus.sv
// Three-port arbiter for the DCPU-16 core onto one simplified Wishbone master.
// Priority CC > AB > F with a starvation override for F, and a BUSY timeout that returns 16'hFFFF.
module dcpu16_mbus #(
    parameter int TMO = 8,
    parameter int STV = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] f_adr,
    input  logic        f_stb,
    output logic [15:0] f_dti,
    output logic        f_ack,
    input  logic [15:0] ab_adr,
    input  logic        ab_stb,
    output logic [15:0] ab_dti,
    output logic        ab_ack,
    input  logic [15:0] cc_adr,
    input  logic        cc_stb,
    input  logic        cc_wre,
    input  logic [15:0] cc_dto,
    output logic [15:0] cc_dti,
    output logic        cc_ack,
    output logic [15:0] wb_adr,
    output logic        wb_stb,
    output logic        wb_wre,
    output logic [15:0] wb_dto,
    input  logic [15:0] wb_dti,
    input  logic        wb_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_F    = 2'd1,
        G_AB   = 2'd2,
        G_CC   = 2'd3
    } grant_t;

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;
    logic [3:0]  starv_q, starv_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] adr_q, adr_d;
    logic        wre_q, wre_d;
    logic [15:0] dto_q, dto_d;
    logic        stb_q, stb_d;
    logic [15:0] f_dti_q, f_dti_d;
    logic [15:0] ab_dti_q, ab_dti_d;
    logic [15:0] cc_dti_q, cc_dti_d;
    logic        f_ack_q, f_ack_d;
    logic        ab_ack_q, ab_ack_d;
    logic        cc_ack_q, cc_ack_d;
    logic        err_q, err_d;

    // Routes a completed read word into the dti register of the granted port.
    function automatic void route_dti(
        input  grant_t      g,
        input  logic [15:0] word,
        inout  logic [15:0] fd,
        inout  logic [15:0] ad,
        inout  logic [15:0] cd
    );
        case (g)
            G_F:     fd = word;
            G_AB:    ad = word;
            G_CC:    cd = word;
            default: fd = fd;
        endcase
    endfunction

    // Next-state, arbitration, timeout and registered-output computation.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starv_d  = starv_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wre_d    = wre_q;
        dto_d    = dto_q;
        stb_d    = 1'b0;
        f_dti_d  = f_dti_q;
        ab_dti_d = ab_dti_q;
        cc_dti_d = cc_dti_q;
        f_ack_d  = 1'b0;
        ab_ack_d = 1'b0;
        cc_ack_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (f_stb || ab_stb || cc_stb) begin
                    state_d = S_BUSY;
                    stb_d   = 1'b1;
                    cnt_d   = 8'd0;
                    // F is forced through once it has lost STV arbitrations in a row.
                    if (f_stb && (starv_q == 4'(STV))) begin
                        grant_d = G_F;
                    end else if (cc_stb) begin
                        grant_d = G_CC;
                    end else if (ab_stb) begin
                        grant_d = G_AB;
                    end else begin
                        grant_d = G_F;
                    end

                    case (grant_d)
                        G_CC: begin
                            adr_d = cc_adr;
                            wre_d = cc_wre;
                            dto_d = cc_dto;
                        end
                        G_AB: begin
                            adr_d = ab_adr;
                            wre_d = 1'b0;
                            dto_d = 16'h0000;
                        end
                        default: begin
                            adr_d = f_adr;
                            wre_d = 1'b0;
                            dto_d = 16'h0000;
                        end
                    endcase

                    if (grant_d == G_F) begin
                        starv_d = 4'd0;
                    end else if (f_stb && (starv_q < 4'(STV))) begin
                        starv_d = starv_q + 4'd1;
                    end else begin
                        starv_d = starv_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (wb_ack) begin
                    state_d = S_DONE;
                    route_dti(grant_q, wb_dti, f_dti_d, ab_dti_d, cc_dti_d);
                end else if (cnt_q == 8'(TMO - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    route_dti(grant_q, 16'hFFFF, f_dti_d, ab_dti_d, cc_dti_d);
                end else begin
                    stb_d = 1'b1;
                end
                if (state_d == S_DONE) begin
                    f_ack_d  = (grant_q == G_F);
                    ab_ack_d = (grant_q == G_AB);
                    cc_ack_d = (grant_q == G_CC);
                end else begin
                    f_ack_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
        endcase
    end

    // State and output registers; reset forces IDLE asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= G_NONE;
            starv_q  <= 4'd0;
            cnt_q    <= 8'd0;
            adr_q    <= 16'h0000;
            wre_q    <= 1'b0;
            dto_q    <= 16'h0000;
            stb_q    <= 1'b0;
            f_dti_q  <= 16'h0000;
            ab_dti_q <= 16'h0000;
            cc_dti_q <= 16'h0000;
            f_ack_q  <= 1'b0;
            ab_ack_q <= 1'b0;
            cc_ack_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starv_q  <= starv_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wre_q    <= wre_d;
            dto_q    <= dto_d;
            stb_q    <= stb_d;
            f_dti_q  <= f_dti_d;
            ab_dti_q <= ab_dti_d;
            cc_dti_q <= cc_dti_d;
            f_ack_q  <= f_ack_d;
            ab_ack_q <= ab_ack_d;
            cc_ack_q <= cc_ack_d;
            err_q    <= err_d;
        end
    end

    assign wb_adr = adr_q;
    assign wb_stb = stb_q;
    assign wb_wre = wre_q;
    assign wb_dto = dto_q;
    assign f_dti  = f_dti_q;
    assign ab_dti = ab_dti_q;
    assign cc_dti = cc_dti_q;
    assign f_ack  = f_ack_q;
    assign ab_ack = ab_ack_q;
    assign cc_ack = cc_ack_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dcpu16_mbus.sv
// Directed bench for dcpu16_mbus: single read, CC/AB priority, F starvation,
// bus timeout, ack-vs-timeout tie, and asynchronous reset mid-transfer.
module tb_dcpu16_mbus;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] f_adr, ab_adr, cc_adr, cc_dto, wb_dti;
    logic        f_stb, ab_stb, cc_stb, cc_wre, wb_ack;
    logic [15:0] f_dti, ab_dti, cc_dti, wb_adr, wb_dto;
    logic        f_ack, ab_ack, cc_ack, wb_stb, wb_wre, err;

    int total = 0;
    int bad   = 0;

    dcpu16_mbus #(.TMO(8), .STV(3)) dut (
        .clk(clk), .rst(rst),
        .f_adr(f_adr), .f_stb(f_stb), .f_dti(f_dti), .f_ack(f_ack),
        .ab_adr(ab_adr), .ab_stb(ab_stb), .ab_dti(ab_dti), .ab_ack(ab_ack),
        .cc_adr(cc_adr), .cc_stb(cc_stb), .cc_wre(cc_wre), .cc_dto(cc_dto),
        .cc_dti(cc_dti), .cc_ack(cc_ack),
        .wb_adr(wb_adr), .wb_stb(wb_stb), .wb_wre(wb_wre), .wb_dto(wb_dto),
        .wb_dti(wb_dti), .wb_ack(wb_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        f_adr = 16'h0000; f_stb = 1'b0;
        ab_adr = 16'h0000; ab_stb = 1'b0;
        cc_adr = 16'h0000; cc_stb = 1'b0; cc_wre = 1'b0; cc_dto = 16'h0000;
        wb_dti = 16'h0000; wb_ack = 1'b0;
        #3;
        chk("rst_wb_stb", 16'(wb_stb), 16'h0000);
        chk("rst_wb_adr", wb_adr, 16'h0000);
        chk("rst_acks", {13'h0000, f_ack, ab_ack, cc_ack}, 16'h0000);
        chk("rst_err", 16'(err), 16'h0000);
        chk("rst_dti_or", f_dti | ab_dti | cc_dti, 16'h0000);
        tick();
        tick();
        rst = 1'b0;

        // Single F read, zero-wait memory
        f_adr = 16'h0010; f_stb = 1'b1;
        tick();
        chk("f_busy_stb", 16'(wb_stb), 16'h0001);
        chk("f_busy_adr", wb_adr, 16'h0010);
        chk("f_busy_wre", 16'(wb_wre), 16'h0000);
        wb_ack = 1'b1; wb_dti = 16'h7C01;
        tick();
        chk("f_done_ack", 16'(f_ack), 16'h0001);
        chk("f_done_dti", f_dti, 16'h7C01);
        chk("f_done_err", 16'(err), 16'h0000);
        chk("f_done_stb", 16'(wb_stb), 16'h0000);
        f_stb = 1'b0; wb_ack = 1'b0;
        tick();
        chk("f_idle_ack", 16'(f_ack), 16'h0000);
        chk("f_idle_dti", f_dti, 16'h7C01);

        // CC write and AB read requested together
        cc_adr = 16'h1000; cc_dto = 16'hBEEF; cc_wre = 1'b1; cc_stb = 1'b1;
        ab_adr = 16'h2000; ab_stb = 1'b1;
        tick();
        chk("cc_adr", wb_adr, 16'h1000);
        chk("cc_wre", 16'(wb_wre), 16'h0001);
        chk("cc_dto", wb_dto, 16'hBEEF);
        wb_ack = 1'b1; wb_dti = 16'h1234;
        tick();
        chk("cc_ack", {14'h0000, cc_ack, ab_ack}, 16'h0002);
        chk("cc_dti", cc_dti, 16'h1234);
        cc_stb = 1'b0; cc_wre = 1'b0; wb_ack = 1'b0;
        tick();
        tick();
        chk("ab_adr", wb_adr, 16'h2000);
        chk("ab_wre", 16'(wb_wre), 16'h0000);
        chk("ab_dto", wb_dto, 16'h0000);
        wb_ack = 1'b1; wb_dti = 16'h5678;
        tick();
        chk("ab_ack", {14'h0000, cc_ack, ab_ack}, 16'h0001);
        chk("ab_dti", ab_dti, 16'h5678);
        chk("cc_dti_hold", cc_dti, 16'h1234);
        ab_stb = 1'b0; wb_ack = 1'b0;
        tick();

        // F starvation: AB wins three times, F the fourth
        f_adr = 16'h0020; f_stb = 1'b1;
        ab_adr = 16'h3000; ab_stb = 1'b1;
        wb_ack = 1'b1; wb_dti = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("starv_ab_adr%0d", i), wb_adr, 16'h3000);
            tick();
            chk($sformatf("starv_acks%0d", i), {14'h0000, f_ack, ab_ack}, 16'h0001);
            tick();
        end
        tick();
        chk("starv_f_adr", wb_adr, 16'h0020);
        tick();
        chk("starv_f_acks", {14'h0000, f_ack, ab_ack}, 16'h0002);
        tick();
        tick();
        chk("starv_clear_adr", wb_adr, 16'h3000);
        tick();
        f_stb = 1'b0; ab_stb = 1'b0; wb_ack = 1'b0;
        tick();

        // AB read with no wb_ack: timeout after 8 BUSY cycles
        ab_adr = 16'h4000; ab_stb = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("tmo_busy%0d", i), {14'h0000, wb_stb, ab_ack}, 16'h0002);
        end
        tick();
        chk("tmo_ack", 16'(ab_ack), 16'h0001);
        chk("tmo_err", 16'(err), 16'h0001);
        chk("tmo_dti", ab_dti, 16'hFFFF);
        chk("tmo_stb", 16'(wb_stb), 16'h0000);
        ab_stb = 1'b0;
        tick();
        chk("tmo_err_pulse", 16'(err), 16'h0000);

        // wb_ack on the timeout cycle wins
        ab_adr = 16'h5000; ab_stb = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("tie_busy8", 16'(wb_stb), 16'h0001);
        wb_ack = 1'b1; wb_dti = 16'h0A5A;
        tick();
        chk("tie_ack", 16'(ab_ack), 16'h0001);
        chk("tie_err", 16'(err), 16'h0000);
        chk("tie_dti", ab_dti, 16'h0A5A);
        ab_stb = 1'b0; wb_ack = 1'b0;
        tick();

        // Asynchronous reset mid-BUSY, then a stray wb_ack
        f_adr = 16'h0030; f_stb = 1'b1;
        tick();
        chk("rb_busy", 16'(wb_stb), 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_stb_async", 16'(wb_stb), 16'h0000);
        f_stb = 1'b0;
        #1;
        rst = 1'b0;
        wb_ack = 1'b1; wb_dti = 16'h9999;
        tick();
        chk("rb_no_ack", {13'h0000, f_ack, ab_ack, cc_ack}, 16'h0000);
        chk("rb_no_stb", 16'(wb_stb), 16'h0000);
        tick();
        chk("rb_no_ack2", 16'(f_ack), 16'h0000);
        chk("rb_dti_clr", f_dti, 16'h0000);
        wb_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
